// File: rtl/elink_tx_scheduler.sv
// Round-robin scheduler sharing one 8b10b E-link TX encoder between N_REQ byte-stream
// requesters; frames each granted packet as SOP / data / EOP and fills gaps with commas.
module elink_tx_scheduler #(
   parameter int N_REQ        = 4,
   parameter int MAX_BYTES    = 16,
   parameter int UNDERRUN_MAX = 8,
   localparam int GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 bitCLKx4,
   input  logic                 rst,
   input  logic                 getDataTrig,
   input  logic [N_REQ-1:0]     chan_en,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [9:0]           EDATA_OUT,
   output logic                 EDATA_RDY,
   output logic [GW-1:0]        grant_id,
   output logic                 busy,
   output logic                 err_len,
   output logic                 err_underrun
);

   typedef enum logic [1:0] {IDLE, SOP, DATA, EOP} state_t;

   localparam logic [9:0] W_SOP   = 10'b10_0000_0000;
   localparam logic [9:0] W_EOP   = 10'b01_0000_0000;
   localparam logic [9:0] W_COMMA = 10'b11_0000_0000;

   state_t              state_q, state_d;
   logic                trig_q;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       last_grant_q, last_grant_d;
   logic [7:0]          byte_cnt_q, byte_cnt_d;
   logic [7:0]          under_cnt_q, under_cnt_d;
   logic [9:0]          edata_q, edata_d;
   logic                rdy_q, rdy_d;
   logic [N_REQ-1:0]    ready_q, ready_d;
   logic                err_len_q, err_len_d;
   logic                err_und_q, err_und_d;
   logic                busy_q, busy_d;

   logic                trig_evt;
   logic [N_REQ-1:0]    cand;
   logic                found;
   logic [GW-1:0]       sel;
   int                  idx;
   logic [7:0]          byte_inc, under_inc;

   assign trig_evt  = getDataTrig & ~trig_q;
   assign cand      = req_valid & chan_en;
   assign byte_inc  = byte_cnt_q + 8'd1;
   assign under_inc = under_cnt_q + 8'd1;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      // Search starts one past the last served requester, wrapping modulo N_REQ.
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_grant_q) + k) % N_REQ;
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = GW'(idx);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      byte_cnt_d   = byte_cnt_q;
      under_cnt_d  = under_cnt_q;
      edata_d      = edata_q;
      rdy_d        = 1'b0;
      ready_d      = '0;
      err_len_d    = 1'b0;
      err_und_d    = 1'b0;

      if (trig_evt) begin
         rdy_d = 1'b1;
         case (state_q)
            IDLE: begin
               if (!found) begin
                  edata_d = W_COMMA;
               end else begin
                  edata_d     = W_SOP;
                  grant_d     = sel;
                  byte_cnt_d  = '0;
                  under_cnt_d = '0;
                  state_d     = DATA;
               end
            end
            DATA: begin
               if (req_valid[grant_q]) begin
                  edata_d          = {2'b00, req_data[8*int'(grant_q) +: 8]};
                  ready_d[grant_q] = 1'b1;
                  byte_cnt_d       = byte_inc;
                  under_cnt_d      = '0;
                  if (req_last[grant_q]) begin
                     state_d = EOP;
                  end else if (byte_inc == 8'(MAX_BYTES)) begin
                     state_d   = EOP;
                     err_len_d = 1'b1;
                  end
               end else begin
                  edata_d     = W_COMMA;
                  under_cnt_d = under_inc;
                  if (under_inc == 8'(UNDERRUN_MAX)) begin
                     state_d   = EOP;
                     err_und_d = 1'b1;
                  end
               end
            end
            EOP: begin
               edata_d      = W_EOP;
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
            default: begin
               edata_d = W_COMMA;
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
   always_ff @(posedge bitCLKx4 or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         trig_q       <= 1'b0;
         grant_q      <= '0;
         last_grant_q <= GW'(N_REQ - 1);
         byte_cnt_q   <= '0;
         under_cnt_q  <= '0;
         edata_q      <= W_COMMA;
         rdy_q        <= 1'b0;
         ready_q      <= '0;
         err_len_q    <= 1'b0;
         err_und_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         trig_q       <= getDataTrig;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         byte_cnt_q   <= byte_cnt_d;
         under_cnt_q  <= under_cnt_d;
         edata_q      <= edata_d;
         rdy_q        <= rdy_d;
         ready_q      <= ready_d;
         err_len_q    <= err_len_d;
         err_und_q    <= err_und_d;
         busy_q       <= busy_d;
      end
   end

   assign EDATA_OUT    = edata_q;
   assign EDATA_RDY    = rdy_q;
   assign req_ready    = ready_q;
   assign grant_id     = grant_q;
   assign busy         = busy_q;
   assign err_len      = err_len_q;
   assign err_underrun = err_und_q;

endmodule

// File: tb/tb_elink_tx_scheduler.sv
// Directed bench for elink_tx_scheduler: idle commas, single packet, round-robin,
// length limit, underrun and mid-packet reset, with hand-computed expected words.
module tb_elink_tx_scheduler;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           trig;
   logic [N-1:0]   chan_en;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [9:0]     EDATA_OUT;
   logic           EDATA_RDY;
   logic [1:0]     grant_id;
   logic           busy;
   logic           err_len;
   logic           err_underrun;

   int n_checks = 0;
   int n_errors = 0;

   elink_tx_scheduler #(.N_REQ(N), .MAX_BYTES(16), .UNDERRUN_MAX(8)) dut (
      .bitCLKx4     (clk),
      .rst          (rst),
      .getDataTrig  (trig),
      .chan_en      (chan_en),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .EDATA_OUT    (EDATA_OUT),
      .EDATA_RDY    (EDATA_RDY),
      .grant_id     (grant_id),
      .busy         (busy),
      .err_len      (err_len),
      .err_underrun (err_underrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic [7:0] d, input logic v, input logic l);
      req_data[8*ch +: 8] = d;
      req_valid[ch]       = v;
      req_last[ch]        = l;
   endtask

   task automatic do_reset();
      @(negedge clk);
      trig = 1'b0;
      rst  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One trigger event held two cycles; checks the strobe cycle and the cycle after.
   task automatic word(input string tag, input logic [9:0] exp_w, input logic [N-1:0] exp_rdy,
                       input logic exp_el, input logic exp_eu);
      @(negedge clk);
      trig = 1'b1;
      @(posedge clk);
      #1;
      check({tag, ".word"},  32'(EDATA_OUT), 32'(exp_w));
      check({tag, ".rdy"},   32'(EDATA_RDY), 32'd1);
      check({tag, ".pop"},   32'(req_ready), 32'(exp_rdy));
      check({tag, ".elen"},  32'(err_len), 32'(exp_el));
      check({tag, ".eund"},  32'(err_underrun), 32'(exp_eu));
      @(posedge clk);
      #1;
      check({tag, ".rdy_off"},  32'(EDATA_RDY), 32'd0);
      check({tag, ".pop_off"},  32'(req_ready), 32'd0);
      check({tag, ".err_off"},  32'({err_len, err_underrun}), 32'd0);
      check({tag, ".hold"},     32'(EDATA_OUT), 32'(exp_w));
      @(negedge clk);
      trig = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int order_a[5];
      int order_b[4];
      order_a = '{0, 1, 2, 3, 0};
      order_b = '{0, 1, 3, 0};

      rst       = 1'b0;
      trig      = 1'b0;
      chan_en   = '1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst.word",  32'(EDATA_OUT), 32'h300);
      check("rst.rdy",   32'(EDATA_RDY), 32'd0);
      check("rst.pop",   32'(req_ready), 32'd0);
      check("rst.grant", 32'(grant_id), 32'd0);
      check("rst.busy",  32'(busy), 32'd0);
      check("rst.err",   32'({err_len, err_underrun}), 32'd0);
      rst = 1'b1;

      // Idle: five commas
      for (int i = 0; i < 5; i++) word("idle", 10'h300, 4'b0000, 1'b0, 1'b0);
      check("idle.busy", 32'(busy), 32'd0);

      // Single packet on channel 2
      set_ch(2, 8'hA1, 1'b1, 1'b0);
      word("p2.sop", 10'h200, 4'b0000, 1'b0, 1'b0);
      check("p2.grant", 32'(grant_id), 32'd2);
      check("p2.busy",  32'(busy), 32'd1);
      word("p2.d0", 10'h0A1, 4'b0100, 1'b0, 1'b0);
      set_ch(2, 8'hB2, 1'b1, 1'b0);
      word("p2.d1", 10'h0B2, 4'b0100, 1'b0, 1'b0);
      set_ch(2, 8'hC3, 1'b1, 1'b1);
      word("p2.d2", 10'h0C3, 4'b0100, 1'b0, 1'b0);
      set_ch(2, 8'h00, 1'b0, 1'b0);
      word("p2.eop", 10'h100, 4'b0000, 1'b0, 1'b0);
      check("p2.busy_eop", 32'(busy), 32'd0);
      word("p2.idle", 10'h300, 4'b0000, 1'b0, 1'b0);
      check("p2.grant_hold", 32'(grant_id), 32'd2);

      // Round-robin, all enabled, one-byte packets
      do_reset();
      for (int c = 0; c < N; c++) set_ch(c, 8'(8'h10 + c), 1'b1, 1'b1);
      for (int p = 0; p < 5; p++) begin
         word("rr.sop", 10'h200, 4'b0000, 1'b0, 1'b0);
         check("rr.grant", 32'(grant_id), 32'(order_a[p]));
         word("rr.data", {2'b00, 8'(8'h10 + order_a[p])}, 4'(1 << order_a[p]), 1'b0, 1'b0);
         word("rr.eop", 10'h100, 4'b0000, 1'b0, 1'b0);
      end

      // Round-robin with channel 2 disabled
      do_reset();
      chan_en = 4'b1011;
      for (int p = 0; p < 4; p++) begin
         word("rrm.sop", 10'h200, 4'b0000, 1'b0, 1'b0);
         check("rrm.grant", 32'(grant_id), 32'(order_b[p]));
         word("rrm.data", {2'b00, 8'(8'h10 + order_b[p])}, 4'(1 << order_b[p]), 1'b0, 1'b0);
         word("rrm.eop", 10'h100, 4'b0000, 1'b0, 1'b0);
      end

      // Length limit: 20 bytes without last, forced EOP after 16
      do_reset();
      chan_en   = '1;
      req_valid = '0;
      req_last  = '0;
      set_ch(0, 8'h40, 1'b1, 1'b0);
      word("len.sop", 10'h200, 4'b0000, 1'b0, 1'b0);
      check("len.grant", 32'(grant_id), 32'd0);
      for (int k = 0; k < 16; k++) begin
         word("len.d", {2'b00, 8'(8'h40 + k)}, 4'b0001, (k == 15), 1'b0);
         set_ch(0, 8'(8'h40 + k + 1), 1'b1, 1'b0);
      end
      word("len.eop", 10'h100, 4'b0000, 1'b0, 1'b0);
      word("len.sop2", 10'h200, 4'b0000, 1'b0, 1'b0);
      check("len.grant2", 32'(grant_id), 32'd0);
      for (int k = 16; k < 20; k++) begin
         set_ch(0, 8'(8'h40 + k), 1'b1, (k == 19));
         word("len.r", {2'b00, 8'(8'h40 + k)}, 4'b0001, 1'b0, 1'b0);
      end
      set_ch(0, 8'h00, 1'b0, 1'b0);
      word("len.eop2", 10'h100, 4'b0000, 1'b0, 1'b0);

      // Underrun on channel 1
      do_reset();
      set_ch(1, 8'h55, 1'b1, 1'b0);
      word("und.sop", 10'h200, 4'b0000, 1'b0, 1'b0);
      check("und.grant", 32'(grant_id), 32'd1);
      word("und.d0", 10'h055, 4'b0010, 1'b0, 1'b0);
      set_ch(1, 8'h55, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         word("und.comma", 10'h300, 4'b0000, 1'b0, (k == 7));
         check("und.busy", 32'(busy), 32'd1);
      end
      word("und.eop", 10'h100, 4'b0000, 1'b0, 1'b0);
      check("und.idle", 32'(busy), 32'd0);

      // Reset mid-packet, with a pop and strobe in flight
      do_reset();
      set_ch(1, 8'h00, 1'b0, 1'b0);
      set_ch(0, 8'h77, 1'b1, 1'b0);
      word("mid.sop", 10'h200, 4'b0000, 1'b0, 1'b0);
      word("mid.d0", 10'h077, 4'b0001, 1'b0, 1'b0);
      @(negedge clk);
      trig = 1'b1;
      @(posedge clk);
      #1;
      check("mid.d1_word", 32'(EDATA_OUT), 32'h077);
      check("mid.d1_pop",  32'(req_ready), 32'b0001);
      #1;
      rst  = 1'b0;
      trig = 1'b0;
      #1;
      check("mid.rst_word",  32'(EDATA_OUT), 32'h300);
      check("mid.rst_rdy",   32'(EDATA_RDY), 32'd0);
      check("mid.rst_pop",   32'(req_ready), 32'd0);
      check("mid.rst_grant", 32'(grant_id), 32'd0);
      check("mid.rst_busy",  32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      word("mid.sop2", 10'h200, 4'b0000, 1'b0, 1'b0);
      check("mid.grant2", 32'(grant_id), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/elink_tx_scheduler.md
# elink_tx_scheduler

Round-robin packet scheduler that shares one 8b10b E-link transmit encoder (`elink_proc_out_enc8b10b`) between N byte-stream requesters. On every encoder data request (`getDataTrig`) it supplies exactly one 10-bit word `{delimeter, byte}` with a one-cycle `EDATA_RDY` strobe, framing each granted packet as SOP, data bytes, EOP, and filling gaps with comma words. It sits between the per-channel TX FIFOs and the E-link encoder in the MOPSHUB uplink path, clocked by `bitCLKx4`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `MAX_BYTES`, 16: maximum data bytes per packet before forced EOP (1..255).
- `UNDERRUN_MAX`, 8: consecutive starved triggers inside a packet before forced EOP (1..255).

Ports:
- `bitCLKx4`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `getDataTrig`  in  1  encoder word request (level from encoder; rising edge = one request).
- `chan_en`  in  N_REQ  per-requester enable; sampled only at grant time.
- `req_valid`  in  N_REQ  requester has a byte available.
- `req_data`  in  8*N_REQ  requester byte; channel i at bits [8i+7:8i].
- `req_last`  in  N_REQ  byte on `req_data` is last of its packet.
- `req_ready`  out  N_REQ  one-cycle pop strobe to granted requester.
- `EDATA_OUT`  out  10  `{delimeter[1:0], data[7:0]}` to encoder `EDATA_IN`.
- `EDATA_RDY`  out  1  one-cycle strobe, `EDATA_OUT` valid.
- `grant_id`  out  clog2(N_REQ)  currently/last granted requester.
- `busy`  out  1  high in SOP/DATA/EOP states.
- `err_len`  out  1  one-cycle pulse on MAX_BYTES forced EOP.
- `err_underrun`  out  1  one-cycle pulse on UNDERRUN_MAX forced EOP.

## Operation
- Delimiter codes: `2'b10` SOP, `2'b00` data, `2'b01` EOP, `2'b11` comma. SOP/EOP/comma words carry data `8'h00`.
- Trigger event: `getDataTrig & ~trig_d` (trig_d = registered `getDataTrig`). Exactly one word per event; events never queue.
- FSM states IDLE, SOP, DATA, EOP; transitions evaluated only on a trigger event:
  - IDLE: candidates = `req_valid & chan_en`. None -> emit comma, stay. Else grant first candidate searching from `last_grant+1` modulo N_REQ, emit SOP, load `grant_id`, clear byte/underrun counters, go DATA.
  - DATA: `req_valid[g]` high -> emit `{2'b00, req_data[g]}`, pulse `req_ready[g]`, byte_cnt+1, underrun_cnt=0; go EOP if `req_last[g]` or byte_cnt+1 == MAX_BYTES (the latter without `req_last` also pulses `err_len`). `req_valid[g]` low -> emit comma, underrun_cnt+1; reaching UNDERRUN_MAX -> go EOP, pulse `err_underrun`.
  - EOP: emit EOP, `last_grant <= g`, go IDLE.
- `chan_en[g]` dropping mid-packet does not abort; packet completes normally.
- Requester retains unpopped bytes after forced EOP; remainder is sent as a new packet on a later grant.
- Counters are 8-bit, saturate-free by construction (cleared at SOP).

## Timing
- Reset (async assert, sync-free release): state IDLE, `EDATA_OUT`=10'b11_0000_0000, `EDATA_RDY`=0, `req_ready`=0, `grant_id`=0, `last_grant`=N_REQ-1 (first grant searches from 0), `busy`=0, `err_*`=0, counters 0, trig_d=0.
- Latency: edge detected in cycle t (trig high, trig_d low); `EDATA_OUT`, `EDATA_RDY`, `req_ready[g]`, `err_*` all registered and valid in cycle t+1 for exactly one cycle. `EDATA_OUT` holds its value until next word.
- `req_data`/`req_last`/`req_valid` sampled in cycle t; requester must present next byte by next trigger edge (≥4 cycles at bitCLK/bitCLKx4 ratio).
- `getDataTrig` held high for multiple cycles = one event; must return low ≥1 cycle between requests.
- Reset mid-packet: packet abandoned without EOP; downstream decoder resyncs on next SOP. Any `req_ready` pulse in flight is cleared.
- `busy` updates in t+1 with state.

## Test plan
- Idle: reset, no `req_valid`, 5 trigger edges -> 5 words 10'h300 each with single-cycle `EDATA_RDY`, `req_ready`=0.
- Single packet: ch2 offers 8'hA1,8'hB2,8'hC3(last) -> words 10'h200, 10'h0A1, 10'h0B2, 10'h0C3, 10'h100, then 10'h300; `req_ready[2]` pulses 3 times; `grant_id`=2.
- Round-robin: all 4 channels valid with 1-byte packets -> grant order 0,1,2,3,0; `chan_en`=4'b1011 -> order 0,1,3,0.
- Length limit: MAX_BYTES=16, ch0 streams 20 bytes without last -> SOP, 16 data, EOP with `err_len` pulse; remaining 4 bytes sent in a later packet.
- Underrun: ch1 sends SOP + 1 byte then drops `req_valid` -> UNDERRUN_MAX (8) comma words, then EOP with `err_underrun` pulse, state IDLE.
- Reset mid-packet: assert `rst` low after 2 data words -> all outputs at reset values asynchronously; after release first trigger yields comma or fresh SOP for requester 0.
